// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code position tracker: step encodings,
// tracker state enum and the Gray-to-binary decode helper.
package gray_pkg;

    // Widest Gray/binary value the decode helper handles
    localparam int unsigned MAX_W = 16;

    // out_dir encodings
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_BAD  = 2'b11;

    // EMPTY: no reference sample held; TRACK: reference held
    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Gray to binary; narrower codes are zero-extended by the caller, which
    // leaves the upper result bits zero and the narrow MSB equal to g[MSB].
    function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_pkg

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary decoder.
// Ports:
//   gray - Gray-coded input (DATA_WIDTH bits)
//   bin  - decoded binary value (DATA_WIDTH bits)
module gray_decode
    import gray_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin
);

    logic [MAX_W-1:0] bin_wide;

    assign bin_wide = gray_to_bin(MAX_W'(gray));
    assign bin      = bin_wide[DATA_WIDTH-1:0];

endmodule : gray_decode

// File: rtl/gray_tracker.sv
// Gray-code position tracker: decodes each accepted Gray sample, classifies
// the step against the previous sample and accumulates a signed position.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   clr                   - synchronous clear of position, sticky error, state
//   in_valid/in_ready     - sample handshake, in_gray is the Gray sample
//   out_valid/out_ready   - result handshake
//   out_bin               - decoded binary value of the sample
//   out_dir               - 00 none, 01 up, 10 down, 11 invalid
//   out_pos               - accumulated position after the sample
//   out_err               - sample broke the single-step rule
//   err_sticky            - any error since the last clr/reset
module gray_tracker
    import gray_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned POS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_gray,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_bin,
    output logic [1:0]            out_dir,
    output logic [POS_WIDTH-1:0]  out_pos,
    output logic                  out_err,
    output logic                  err_sticky
);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   ref_q, ref_d;
    logic [POS_WIDTH-1:0]    pos_q, pos_d;
    logic                    sticky_q, sticky_d;
    logic                    vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   bin_q, bin_d;
    logic [1:0]              dir_q, dir_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   new_bin;
    logic [DATA_WIDTH-1:0]   ref_gray;
    logic [DATA_WIDTH-1:0]   flip_bits;
    logic [DATA_WIDTH-1:0]   bin_diff;
    logic                    accept;
    logic                    same;
    logic                    one_flip;
    logic                    step_up;
    logic                    step_down;

    gray_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
        .gray(in_gray),
        .bin (new_bin)
    );

    // Handshake: clr blocks acceptance, a held result blocks until consumed
    assign in_ready = !clr && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Step classification against the stored reference
    assign ref_gray  = ref_q ^ (ref_q >> 1);
    assign flip_bits = in_gray ^ ref_gray;
    assign same      = (flip_bits == '0);
    assign one_flip  = $onehot(flip_bits);
    assign bin_diff  = DATA_WIDTH'(new_bin - ref_q);
    assign step_up   = (bin_diff == DATA_WIDTH'(1));
    assign step_down = (bin_diff == '1);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            ref_q    <= '0;
            pos_q    <= '0;
            sticky_q <= 1'b0;
            vld_q    <= 1'b0;
            bin_q    <= '0;
            dir_q    <= DIR_NONE;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            pos_q    <= pos_d;
            sticky_q <= sticky_d;
            vld_q    <= vld_d;
            bin_q    <= bin_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    // Next-state and result computation
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        pos_d    = pos_q;
        sticky_d = sticky_q;
        vld_d    = vld_q;
        bin_d    = bin_q;
        dir_d    = dir_q;
        err_d    = err_q;

        if (clr) begin
            state_d  = EMPTY;
            ref_d    = '0;
            pos_d    = '0;
            sticky_d = 1'b0;
            vld_d    = 1'b0;
        end else if (accept) begin
            vld_d   = 1'b1;
            bin_d   = new_bin;
            ref_d   = new_bin;
            dir_d   = DIR_NONE;
            err_d   = 1'b0;
            state_d = TRACK;
            case (state_q)
                EMPTY: begin
                    dir_d = DIR_NONE;
                end
                TRACK: begin
                    if (same) begin
                        dir_d = DIR_NONE;
                    end else if (one_flip && step_up) begin
                        dir_d = DIR_UP;
                        pos_d = pos_q + POS_WIDTH'(1);
                    end else if (one_flip && step_down) begin
                        dir_d = DIR_DOWN;
                        pos_d = pos_q - POS_WIDTH'(1);
                    end else begin
                        // Multi-bit change, or a single flip that is not a
                        // neighbouring code: position unknown, resync on it.
                        dir_d    = DIR_BAD;
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    assign out_valid  = vld_q;
    assign out_bin    = bin_q;
    assign out_dir    = dir_q;
    assign out_pos    = pos_q;
    assign out_err    = err_q;
    assign err_sticky = sticky_q;

endmodule : gray_tracker
